btn_debouncer: RTL and testbench



---
 rtl/btn_debouncer.sv | 100 ++++++++++
 tb/tb_btn_debouncer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// Push-button input conditioning: two-flop synchronizer, per-channel stability
// counter, debounced level and one-cycle press/release strobes.

module btn_deb_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        s1_d    = btn_i;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s2_q == level_q) begin
            // Any return to the accepted level discards the partial count.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = s2_q;
            press_d = s2_q;
            rel_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

module btn_debouncer #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    // Channels are fully independent; no state is shared between lanes.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        btn_deb_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_debouncer.sv
// Randomized + directed bench; a window-based reference model feeds a scoreboard
// that a separate monitor drains every cycle.

module tb_btn_debouncer;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          any_press;

    btn_debouncer #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic          any;
    } exp_t;

    exp_t          sb[$];
    logic [NB-1:0] hb[$];
    logic          hr[$];
    logic [NB-1:0] m_level = '0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            done = 1'b0;

    // Value the logic compares at edge j: the pin sampled two edges earlier,
    // or 0 if either of the two edges in between was a reset edge.
    function automatic logic [NB-1:0] seen(input int j);
        if (j >= 2 && !hr[j-1] && !hr[j-2]) return hb[j-2];
        return '0;
    endfunction

    // Reference: a channel accepts a new level at edge k exactly when the last
    // D compared values are all non-reset and all differ from the current level.
    initial begin
        forever begin
            exp_t          e;
            int            k;
            logic [NB-1:0] fire, old, s;
            bit            ok;
            @(posedge clk);
            hb.push_back(btn);
            hr.push_back(rst);
            k    = hb.size() - 1;
            old  = m_level;
            fire = '0;
            if (rst) begin
                m_level = '0;
            end else begin
                for (int ch = 0; ch < NB; ch++) begin
                    ok = (k >= D - 1);
                    for (int j = k - D + 1; ok && j <= k; j++) begin
                        s = seen(j);
                        if (hr[j] || s[ch] == old[ch]) ok = 1'b0;
                    end
                    fire[ch] = ok;
                end
                m_level = old ^ fire;
            end
            e.level = m_level;
            e.press = fire & ~old;
            e.rel   = fire & old;
            e.any   = |e.press;
            sb.push_back(e);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            exp_t e;
            @(negedge clk);
            if (!done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if (btn_level !== e.level || btn_press !== e.press ||
                        btn_release !== e.rel || any_press !== e.any) begin
                        miscompares++;
                        $display("FAIL outputs at %0t: got lvl=%b prs=%b rel=%b any=%b, want lvl=%b prs=%b rel=%b any=%b",
                                 $time, btn_level, btn_press, btn_release, any_press,
                                 e.level, e.press, e.rel, e.any);
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [NB-1:0] b, input int n);
        rst = r;
        btn = b;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [NB-1:0] nb;
        int            n;
        logic          r;
        // Reset with all buttons held, then hold through acceptance.
        drive(1'b1, 4'b1111, 3);
        drive(1'b0, 4'b1111, 10);
        drive(1'b0, 4'b0000, 10);
        // Clean press and release on channel 1.
        drive(1'b0, 4'b0010, 10);
        drive(1'b0, 4'b0000, 10);
        // Bounce on channel 2, then hold.
        drive(1'b0, 4'b0100, 1);
        drive(1'b0, 4'b0000, 1);
        drive(1'b0, 4'b0100, 1);
        drive(1'b0, 4'b0000, 1);
        drive(1'b0, 4'b0100, 10);
        drive(1'b0, 4'b0000, 10);
        // Short glitch on channel 3.
        drive(1'b0, 4'b1000, 3);
        drive(1'b0, 4'b0000, 10);
        // Simultaneous press on channels 0 and 2.
        drive(1'b0, 4'b0101, 10);
        drive(1'b0, 4'b0000, 10);
        // Reset in the middle of a count on channel 0.
        drive(1'b0, 4'b0001, 4);
        drive(1'b1, 4'b0001, 1);
        drive(1'b0, 4'b0001, 12);
        drive(1'b0, 4'b0000, 10);
        // Random mix of holds, bounces and occasional resets.
        repeat (400) begin
            nb = btn ^ NB'($urandom);
            n  = $urandom_range(1, 9);
            r  = ($urandom_range(0, 24) == 0);
            if (r) n = $urandom_range(1, 2);
            drive(r, nb, n);
        end
        drive(1'b0, '0, 12);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
